// File: rtl/cnnout_reader_if.sv
// Store read port plus output sample stream of the CNN output reader.
// The master side is the reader; the slave side is store mux + downstream stage.
interface cnnout_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              read_start;
  logic [ADDR_W-1:0] readaddrram;
  logic [5:0]        i;
  logic [DATA_W-1:0] data_outcnn;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output read_start, readaddrram, i, out_data, out_valid,
    input  data_outcnn, out_ready
  );

  modport slave (
    input  read_start, readaddrram, i, out_data, out_valid,
    output data_outcnn, out_ready
  );
endinterface

// File: rtl/cnnout_reader.sv
// Drains the multi-channel CNN output store channel-major onto a valid/ready stream,
// issuing reads against FIFO credits so backpressure never overflows the FIFO.
module cnnout_reader #(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              global_rst,
  input  logic              end_cnnbm,
  input  logic [ADDR_W-1:0] frame_len,
  output logic              busy,
  output logic              done,
  cnnout_reader_if.master   bus
);
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [5:0] CH_LAST = 6'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                   state_q;
  logic                     end_q, busy_q, done_q;
  logic [ADDR_W-1:0]        len_q, addr_q, hold_q;
  logic [5:0]               ch_q, i_q;
  logic [RD_LAT:1]          vld_pipe;
  logic [RD_LAT-1:1][5:0]   ch_pipe;
  logic [FIFO_D-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            cnt_q;
  logic                     ov_q;
  logic [DATA_W-1:0]        od_q;

  logic       start, issue, push, pop, drained;
  logic [7:0] occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign start   = end_cnnbm && !end_q && !busy_q && (state_q == IDLE);
  assign push    = vld_pipe[RD_LAT];
  assign pop     = (cnt_q != '0) && (!ov_q || bus.out_ready);
  // Credit = FIFO entries + reads still in the BRAM pipe, minus the slot freed this cycle.
  assign occ     = 8'(cnt_q) + 8'($countones(vld_pipe));
  assign issue   = (state_q == READ) && (occ < 8'(FIFO_D) + 8'(pop));
  assign drained = (vld_pipe == '0) && (cnt_q == '0) && (!ov_q || bus.out_ready);

  // Idle cycles keep re-reading the last address; the valid pipe discards that data.
  assign bus.readaddrram = issue ? addr_q : hold_q;
  assign bus.read_start  = busy_q;
  assign bus.i           = i_q;
  assign bus.out_data    = od_q;
  assign bus.out_valid   = ov_q;
  assign busy            = busy_q;
  assign done            = done_q;

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      state_q <= IDLE;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
      ch_q    <= '0;
    end else begin
      end_q  <= end_cnnbm;
      done_q <= 1'b0;
      hold_q <= bus.readaddrram;
      if (issue) begin
        if (addr_q == len_q - ADDR_W'(1)) begin
          addr_q <= '0;
          ch_q   <= ch_q + 1'b1;
          if (ch_q == CH_LAST) state_q <= DRAIN;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            len_q  <= frame_len;
            addr_q <= '0;
            ch_q   <= '0;
            if (frame_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end
        end
        DRAIN: if (drained) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: ;
      endcase
    end
  end

  // Issue pipe; i follows the returning data, not the current issue.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      vld_pipe <= '0;
      ch_pipe  <= '0;
      i_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
    end else begin
      vld_pipe[1] <= issue;
      ch_pipe[1]  <= ch_q;
      for (int s = 2; s <= RD_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
      for (int s = 2; s < RD_LAT; s++)  ch_pipe[s]  <= ch_pipe[s-1];
      if (vld_pipe[RD_LAT-1]) i_q <= ch_pipe[RD_LAT-1];
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        od_q     <= mem[rd_ptr_q];
        ov_q     <= 1'b1;
      end else if (bus.out_ready) begin
        ov_q <= 1'b0;
      end
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.data_outcnn;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!global_rst)
    !(push && !pop && (cnt_q == CW'(FIFO_D))));
endmodule
